// File: rtl/fc_layer_seq.sv
// rtl/fc_layer_seq.sv - fully-connected layer sequencer with FP16 MAC datapath

// FP16 multiply, round-to-nearest-even; subnormal inputs and results flush to signed zero.
module fp16_mul (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic              sy;
    logic [21:0]       prod;
    logic [21:0]       norm;
    logic signed [7:0] e;
    logic [11:0]       mr;
    logic              rnd;

    assign a_nan  = (a[14:10] == 5'h1f) && (a[9:0] != 10'h0);
    assign b_nan  = (b[14:10] == 5'h1f) && (b[9:0] != 10'h0);
    assign a_inf  = (a[14:10] == 5'h1f) && (a[9:0] == 10'h0);
    assign b_inf  = (b[14:10] == 5'h1f) && (b[9:0] == 10'h0);
    assign a_zero = (a[14:10] == 5'h00);
    assign b_zero = (b[14:10] == 5'h00);

    // Significand product, normalise to a leading one in bit 21, round, then classify.
    always_comb begin
        sy   = a[15] ^ b[15];
        prod = {11'h0, 1'b1, a[9:0]} * {11'h0, 1'b1, b[9:0]};
        norm = prod[21] ? prod : {prod[20:0], 1'b0};
        e    = $signed({3'b000, a[14:10]}) + $signed({3'b000, b[14:10]})
             - 8'sd15 + $signed({7'h00, prod[21]});
        rnd  = norm[10] & ((|norm[9:0]) | norm[11]);
        mr   = {1'b0, norm[21:11]} + {11'h000, rnd};
        if (mr[11]) begin
            mr = mr >> 1;
            e  = e + 8'sd1;
        end
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            y = 16'h7e00;
        else if (a_inf || b_inf)
            y = {sy, 5'h1f, 10'h000};
        else if (a_zero || b_zero)
            y = {sy, 15'h0000};
        else if (e >= 8'sd31)
            y = {sy, 5'h1f, 10'h000};
        else if (e <= 8'sd0)
            y = {sy, 15'h0000};
        else
            y = {sy, e[4:0], mr[9:0]};
    end
endmodule

// FP16 add, round-to-nearest-even; subnormal inputs and results flush to signed zero.
module fp16_add (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [15:0]       x;
    logic [15:0]       z;
    logic [4:0]        d;
    logic [13:0]       mx_ext;
    logic [42:0]       ext_sh;
    logic [13:0]       aligned;
    logic [14:0]       sum;
    logic [13:0]       diff;
    logic [13:0]       n;
    logic [3:0]        lz;
    logic              found;
    logic signed [7:0] e;
    logic [11:0]       mr;
    logic              rnd;

    assign a_nan  = (a[14:10] == 5'h1f) && (a[9:0] != 10'h0);
    assign b_nan  = (b[14:10] == 5'h1f) && (b[9:0] != 10'h0);
    assign a_inf  = (a[14:10] == 5'h1f) && (a[9:0] == 10'h0);
    assign b_inf  = (b[14:10] == 5'h1f) && (b[9:0] == 10'h0);
    assign a_zero = (a[14:10] == 5'h00);
    assign b_zero = (b[14:10] == 5'h00);

    // Align the smaller magnitude with guard/round/sticky, add or subtract, normalise, round.
    always_comb begin
        x = a;
        z = b;
        if (b[14:0] > a[14:0]) begin
            x = b;
            z = a;
        end
        d       = x[14:10] - z[14:10];
        mx_ext  = {1'b1, x[9:0], 3'b000};
        ext_sh  = {1'b1, z[9:0], 32'h0} >> d;
        aligned = {ext_sh[42:30], ext_sh[29] | (|ext_sh[28:0])};
        sum     = {1'b0, mx_ext} + {1'b0, aligned};
        diff    = mx_ext - aligned;
        lz      = 4'd0;
        found   = 1'b0;
        for (int i = 13; i >= 0; i--) begin
            if (!found) begin
                if (diff[i])
                    found = 1'b1;
                else
                    lz = lz + 4'd1;
            end
        end
        if (x[15] == z[15]) begin
            if (sum[14]) begin
                n = {sum[14:2], sum[1] | sum[0]};
                e = $signed({3'b000, x[14:10]}) + 8'sd1;
            end else begin
                n = sum[13:0];
                e = $signed({3'b000, x[14:10]});
            end
        end else begin
            n = diff << lz;
            e = $signed({3'b000, x[14:10]}) - $signed({4'h0, lz});
        end
        rnd = n[2] & (n[1] | n[0] | n[3]);
        mr  = {1'b0, n[13:3]} + {11'h000, rnd};
        if (mr[11]) begin
            mr = mr >> 1;
            e  = e + 8'sd1;
        end
        if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15])))
            y = 16'h7e00;
        else if (a_inf)
            y = {a[15], 5'h1f, 10'h000};
        else if (b_inf)
            y = {b[15], 5'h1f, 10'h000};
        else if (a_zero && b_zero)
            y = {a[15] & b[15], 15'h0000};
        else if (a_zero)
            y = b;
        else if (b_zero)
            y = a;
        else if ((x[15] != z[15]) && (diff == 14'h0))
            y = 16'h0000;
        else if (e >= 8'sd31)
            y = {x[15], 5'h1f, 10'h000};
        else if (e <= 8'sd0)
            y = {x[15], 15'h0000};
        else
            y = {x[15], e[4:0], mr[9:0]};
    end
endmodule

// ReLU: anything with the sign bit set (including -0.0 and negative NaN) becomes +0.
module relu_fp16 (
    input  logic [15:0] a,
    output logic [15:0] y
);
    assign y = a[15] ? 16'h0000 : a;
endmodule

// Four-lane FP16 dot product: lane k uses bits [16k+15:16k] of each word, summed as a balanced tree.
module mac4_fp16 (
    input  logic [63:0] act,
    input  logic [63:0] wgt,
    output logic [15:0] y
);
    logic [15:0] p [4];
    logic [15:0] s01;
    logic [15:0] s23;

    for (genvar k = 0; k < 4; k++) begin : g_lane
        fp16_mul u_mul (.a(act[16*k +: 16]), .b(wgt[16*k +: 16]), .y(p[k]));
    end

    fp16_add u_add01 (.a(p[0]), .b(p[1]), .y(s01));
    fp16_add u_add23 (.a(p[2]), .b(p[3]), .y(s23));
    fp16_add u_add_t (.a(s01),  .b(s23),  .y(y));
endmodule

module fc_layer_seq #(
    parameter int IN_LEN  = 8,
    parameter int OUT_LEN = 4,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              relu_en,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] act_addr,
    input  logic [63:0]       act_rdata,
    output logic [ADDR_W-1:0] w_addr,
    input  logic [63:0]       w_rdata,
    output logic              out_we,
    output logic [ADDR_W-1:0] out_addr,
    output logic [15:0]       out_wdata
);
    localparam int              G      = IN_LEN / 4;
    localparam logic [ADDR_W-1:0] G_A    = ADDR_W'(G);
    localparam logic [ADDR_W-1:0] G_LAST = ADDR_W'(G - 1);
    localparam logic [ADDR_W-1:0] O_LAST = ADDR_W'(OUT_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ACCUM,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] g;
    logic [ADDR_W-1:0] o;
    logic [15:0]       acc;
    logic              relu_q;
    logic [15:0]       mac_y;
    logic [15:0]       acc_sum;
    logic [15:0]       relu_y;
    logic              last_g;
    logic              last_o;

    mac4_fp16 u_mac  (.act(act_rdata), .wgt(w_rdata), .y(mac_y));
    fp16_add  u_acc  (.a(acc), .b(mac_y), .y(acc_sum));
    relu_fp16 u_relu (.a(acc), .y(relu_y));

    assign last_g = (g == G_LAST);
    assign last_o = (o == O_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Next state and outputs; addresses stay stable across FETCH and the following ACCUM.
    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        done      = 1'b0;
        out_we    = 1'b0;
        act_addr  = '0;
        w_addr    = '0;
        out_addr  = '0;
        out_wdata = 16'h0000;
        case (state)
            S_IDLE: begin
                if (start)
                    state_nx = S_FETCH;
            end
            S_FETCH: begin
                busy     = 1'b1;
                act_addr = g;
                w_addr   = o * G_A + g;
                state_nx = S_ACCUM;
            end
            S_ACCUM: begin
                busy     = 1'b1;
                act_addr = g;
                w_addr   = o * G_A + g;
                state_nx = last_g ? S_WRITE : S_FETCH;
            end
            S_WRITE: begin
                busy      = 1'b1;
                out_we    = 1'b1;
                out_addr  = o;
                out_wdata = relu_q ? relu_y : acc;
                state_nx  = last_o ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Group/neuron counters, accumulator and the ReLU mode captured at start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g      <= '0;
            o      <= '0;
            acc    <= 16'h0000;
            relu_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        relu_q <= relu_en;
                        g      <= '0;
                        o      <= '0;
                        acc    <= 16'h0000;
                    end
                end
                S_ACCUM: begin
                    acc <= acc_sum;
                    g   <= last_g ? '0 : g + 1'b1;
                end
                S_WRITE: begin
                    acc <= 16'h0000;
                    if (!last_o)
                        o <= o + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_layer_seq.sv
// tb/tb_fc_layer_seq.sv - scoreboard bench for fc_layer_seq
module tb_fc_layer_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        relu_en = 1'b0;
    logic        busy;
    logic        done;
    logic [7:0]  act_addr;
    logic [63:0] act_rdata;
    logic [7:0]  w_addr;
    logic [63:0] w_rdata;
    logic        out_we;
    logic [7:0]  out_addr;
    logic [15:0] out_wdata;

    logic [63:0] act_mem [0:255];
    logic [63:0] w_mem   [0:255];
    logic [15:0] ival    [0:7] = '{16'h0000, 16'h3c00, 16'h4000, 16'h4200,
                                   16'h4400, 16'h4500, 16'h4600, 16'h4700};
    logic [23:0] exp_q [$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          nwrites = 0;

    fc_layer_seq #(.IN_LEN(8), .OUT_LEN(4), .ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .relu_en(relu_en),
        .busy(busy), .done(done),
        .act_addr(act_addr), .act_rdata(act_rdata),
        .w_addr(w_addr), .w_rdata(w_rdata),
        .out_we(out_we), .out_addr(out_addr), .out_wdata(out_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        act_rdata <= act_mem[act_addr];
        w_rdata   <= w_mem[w_addr];
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    // Monitor: every write strobe is matched against the head of the expectation queue.
    always @(negedge clk) begin
        logic [23:0] e;
        if (rst_n) begin
            if (out_we) begin
                nwrites++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got addr %h data %h required no write", out_addr, out_wdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_addr", 32'(out_addr), 32'(e[23:16]));
                    chk("write_data", 32'(out_wdata), 32'(e[15:0]));
                end
            end else if (out_addr !== 8'h00 || out_wdata !== 16'h0000) begin
                tests++;
                fails++;
                $display("FAIL idle_outputs: got addr %h data %h required 00/0000", out_addr, out_wdata);
            end
        end
    end

    task automatic push4(input logic [15:0] d0, input logic [15:0] d1,
                         input logic [15:0] d2, input logic [15:0] d3);
        exp_q.push_back({8'd0, d0});
        exp_q.push_back({8'd1, d1});
        exp_q.push_back({8'd2, d2});
        exp_q.push_back({8'd3, d3});
    endtask

    task automatic fill_const(input logic [63:0] a, input logic [63:0] w);
        for (int i = 0; i < 8; i++) begin
            act_mem[i] = a;
            w_mem[i]   = w;
        end
    endtask

    // One pass: optional extra start pulses mid-pass and in DONE, optional relu_en toggling.
    task automatic run_pass(input string name, input logic relu, input bit poke, input bit toggle);
        int t0;
        int first;
        int ndone;
        int w0;
        w0      = nwrites;
        relu_en = relu;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0    = cyc;
        first = -1;
        ndone = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            start = poke && (k == 3 || k == 20);
            if (toggle)
                relu_en = ~relu;
            if (k == 1)
                chk({name, "_busy"}, 32'(busy), 32'd1);
            @(negedge clk);
            if (done) begin
                ndone++;
                if (first < 0)
                    first = cyc - t0;
                chk({name, "_busy_in_done"}, 32'(busy), 32'd0);
            end
        end
        start   = 1'b0;
        relu_en = 1'b0;
        chk({name, "_done_latency"}, 32'(first), 32'd20);
        chk({name, "_done_count"}, 32'(ndone), 32'd1);
        chk({name, "_write_count"}, 32'(nwrites - w0), 32'd4);
        chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int t0;
        int w0;
        int ndone;
        int nlow;
        int dt [3];
        for (int i = 0; i < 256; i++) begin
            act_mem[i] = 64'h0;
            w_mem[i]   = 64'h0;
        end

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_out_we", 32'(out_we), 32'd0);
        chk("rst_act_addr", 32'(act_addr), 32'd0);
        chk("rst_w_addr", 32'(w_addr), 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        chk("rst_out_wdata", 32'(out_wdata), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", 32'(busy), 32'd0);

        // All ones: each neuron sums eight 1.0 products
        fill_const({4{16'h3c00}}, {4{16'h3c00}});
        push4(16'h4800, 16'h4800, 16'h4800, 16'h4800);
        run_pass("ones", 1'b0, 1'b0, 1'b0);

        // Neuron 1 weights -1.0: ReLU clamps it, then raw -8.0 with relu_en toggled mid-pass
        w_mem[2] = {4{16'hbc00}};
        w_mem[3] = {4{16'hbc00}};
        push4(16'h4800, 16'h0000, 16'h4800, 16'h4800);
        run_pass("relu_on", 1'b1, 1'b0, 1'b0);
        push4(16'h4800, 16'hc800, 16'h4800, 16'h4800);
        run_pass("relu_off", 1'b0, 1'b0, 1'b1);

        // Addressing: weight word i carries i in lane0, activation lane0 = 1.0
        for (int i = 0; i < 8; i++) begin
            act_mem[i] = 64'h0000_0000_0000_3c00;
            w_mem[i]   = {48'h0, ival[i]};
        end
        push4(16'h3c00, 16'h4500, 16'h4880, 16'h4a80);
        run_pass("addr", 1'b0, 1'b0, 1'b0);

        // Extra start pulses mid-pass and during DONE are ignored
        fill_const({4{16'h3c00}}, {4{16'h3c00}});
        push4(16'h4800, 16'h4800, 16'h4800, 16'h4800);
        run_pass("restart", 1'b0, 1'b1, 1'b0);

        // Reset during ACCUM of neuron 2
        exp_q.push_back({8'd0, 16'h4800});
        exp_q.push_back({8'd1, 16'h4800});
        w0      = nwrites;
        relu_en = 1'b0;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        chk("mid_w_addr", 32'(w_addr), 32'd4);
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_out_we", 32'(out_we), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_w_addr", 32'(w_addr), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ndone = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy)
                ndone++;
        end
        chk("arst_quiet", 32'(ndone), 32'd0);
        chk("arst_writes", 32'(nwrites - w0), 32'd2);
        chk("arst_queue_empty", 32'(exp_q.size()), 32'd0);
        push4(16'h4800, 16'h4800, 16'h4800, 16'h4800);
        run_pass("after_rst", 1'b0, 1'b0, 1'b0);

        // start held high: back-to-back passes
        for (int i = 0; i < 8; i++) begin
            act_mem[i] = 64'h0000_0000_0000_3c00;
            w_mem[i]   = {48'h0, ival[i]};
        end
        for (int p = 0; p < 3; p++)
            push4(16'h3c00, 16'h4500, 16'h4880, 16'h4a80);
        w0    = nwrites;
        ndone = 0;
        nlow  = 0;
        for (int i = 0; i < 3; i++)
            dt[i] = -1;
        start = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        for (int k = 1; k <= 90; k++) begin
            @(posedge clk); #1;
            start = (k < 60);
            @(negedge clk);
            if (done) begin
                if (ndone < 3)
                    dt[ndone] = cyc - t0;
                ndone++;
            end
            if (k <= 64 && !busy)
                nlow++;
            if (k == 21)
                chk("hold_idle_gap", 32'({busy, done}), 32'd0);
        end
        start = 1'b0;
        chk("hold_done_count", 32'(ndone), 32'd3);
        chk("hold_done0", 32'(dt[0]), 32'd20);
        chk("hold_done1", 32'(dt[1]), 32'd42);
        chk("hold_done2", 32'(dt[2]), 32'd64);
        chk("hold_busy_low", 32'(nlow), 32'd5);
        chk("hold_writes", 32'(nwrites - w0), 32'd12);
        chk("hold_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
